// File: rtl/div_radix2_unsigned_pkg.sv
// Shared types for the radix-2 restoring unsigned divider.
package div_radix2_unsigned_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero count; an all-zero input returns DATA_WIDTH.
module div_clz #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         i_value,
    output logic [$clog2(DATA_WIDTH):0]   o_count
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        o_count = CW'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i_value[i]) begin
                o_count = CW'(DATA_WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_radix2_unsigned.sv
// Iterative radix-2 restoring unsigned divider with one-cycle start/done handshake.
// Optional DIV_LEADING_ZERO_SKIP_EN: skips the dividend's leading zeros to shorten latency.
module div_radix2_unsigned
    import div_radix2_unsigned_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done,
    output logic                  divisor_is_zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [W-1:0]      r_rem;
    logic [W-1:0]      r_quo;
    logic [W-1:0]      r_divisor;
    logic [W-1:0]      r_quotient;
    logic [W-1:0]      r_remainder;
    logic              r_dz;

    div_state_t        w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [W-1:0]      w_rem_next;
    logic [W-1:0]      w_quo_next;
    logic [W-1:0]      w_divisor_next;
    logic [W-1:0]      w_quotient_next;
    logic [W-1:0]      w_remainder_next;
    logic              w_dz_next;

    logic [W-1:0]      w_load_q;
    logic [CNT_W-1:0]  w_load_cnt;
    logic              w_load_zero;

`ifdef DIV_LEADING_ZERO_SKIP_EN
    localparam int CW = CNT_W + 1;
    logic [CW-1:0]     w_clz;

    div_clz #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clz (
        .i_value (dividend),
        .o_count (w_clz)
    );

    assign w_load_q    = dividend << w_clz;
    assign w_load_cnt  = CNT_W'(CW'(W - 1) - w_clz);
    assign w_load_zero = (w_clz == CW'(W));
`else
    assign w_load_q    = dividend;
    assign w_load_cnt  = CNT_W'(W - 1);
    assign w_load_zero = 1'b0;
`endif

    // The bit shifted out of r is kept as a carry so r<<1 never overflows.
    logic [W:0]        w_r_ext;
    logic [W+1:0]      w_diff;
    logic              w_fits;
    logic [W-1:0]      w_rem_step;
    logic [W-1:0]      w_quo_step;

    assign w_r_ext    = {r_rem, r_quo[W-1]};
    assign w_diff     = {1'b0, w_r_ext} - {2'b00, r_divisor};
    // A non-negative difference is always below the divisor, so bit W is clear too.
    assign w_fits     = (w_diff[W+1:W] == 2'b00);
    assign w_rem_step = w_fits ? w_diff[W-1:0] : w_r_ext[W-1:0];
    assign w_quo_step = {r_quo[W-2:0], w_fits};

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rem_next       = r_rem;
        w_quo_next       = r_quo;
        w_divisor_next   = r_divisor;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_dz_next        = r_dz;

        if (start) begin
            // A start in any state (re)loads the datapath; a running op is abandoned.
            w_divisor_next = divisor;
            w_rem_next     = '0;
            w_quo_next     = w_load_q;
            w_cnt_next     = w_load_cnt;
            if (divisor == '0) begin
                w_state_next     = DONE;
                w_quotient_next  = '1;
                w_remainder_next = dividend;
                w_dz_next        = 1'b1;
            end else if (w_load_zero) begin
                w_state_next     = DONE;
                w_quotient_next  = '0;
                w_remainder_next = '0;
                w_dz_next        = 1'b0;
            end else begin
                w_state_next = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    w_rem_next = w_rem_step;
                    w_quo_next = w_quo_step;
                    if (r_cnt == '0) begin
                        w_state_next     = DONE;
                        w_quotient_next  = w_quo_step;
                        w_remainder_next = w_rem_step;
                        w_dz_next        = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rem       <= w_rem_next;
            r_quo       <= w_quo_next;
            r_divisor   <= w_divisor_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_dz        <= w_dz_next;
        end
    end

    assign quotient        = r_quotient;
    assign remainder       = r_remainder;
    assign divisor_is_zero = r_dz;
    assign done            = (r_state == DONE);

endmodule

// File: tb/tb_div_radix2_unsigned.sv
// Self-checking bench for div_radix2_unsigned: vector table, corner sequences and random ops
// scored through an expected-result queue; honours DIV_LEADING_ZERO_SKIP_EN for latency.
module tb_div_radix2_unsigned;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          done;
    logic          divisor_is_zero;

    div_radix2_unsigned #(
        .DATA_WIDTH (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dividend        (dividend),
        .divisor         (divisor),
        .quotient        (quotient),
        .remainder       (remainder),
        .done            (done),
        .divisor_is_zero (divisor_is_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           done_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    exp_t          sb[$];
    int            cyc = 0;
    logic          rst_q = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [W-1:0]  held_q = '0;
    logic [W-1:0]  held_r = '0;
    logic          held_dz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clz(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return W - 1 - i;
        end
        return W;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 1;
`ifdef DIV_LEADING_ZERO_SKIP_EN
        if (a == '0) return 1;
        return W + 1 - clz(a);
`else
        return W + 1;
`endif
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Monitor: reset values, scoreboard on done, output holding otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_q) begin
            chk("reset_done", {63'd0, done}, 64'd0);
            chk("reset_quotient", {32'd0, quotient}, 64'd0);
            chk("reset_remainder", {32'd0, remainder}, 64'd0);
            chk("reset_dz", {63'd0, divisor_is_zero}, 64'd0);
            held_q  = '0;
            held_r  = '0;
            held_dz = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
                held_q  = quotient;
                held_r  = remainder;
                held_dz = divisor_is_zero;
            end else begin
                e = sb.pop_front();
                $display("op done cyc=%0d q=0x%08h r=0x%08h dz=%0b", cyc, quotient, remainder, divisor_is_zero);
                chk("quotient", {32'd0, quotient}, {32'd0, e.q});
                chk("remainder", {32'd0, remainder}, {32'd0, e.r});
                chk("divisor_is_zero", {63'd0, divisor_is_zero}, {63'd0, e.dz});
                chk("latency_cycle", 64'(cyc), 64'(e.done_cyc));
                held_q  = e.q;
                held_r  = e.r;
                held_dz = e.dz;
            end
        end else begin
            chk("hold_quotient", {32'd0, quotient}, {32'd0, held_q});
            chk("hold_remainder", {32'd0, remainder}, {32'd0, held_r});
            chk("hold_dz", {63'd0, divisor_is_zero}, {63'd0, held_dz});
        end
    end

    // Called at a negedge; drives a one-cycle start and returns one negedge later.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        if (sb.size() > 0 && sb[$].done_cyc > cyc) begin
            void'(sb.pop_back());
        end
        e.q        = q;
        e.r        = r;
        e.dz       = dz;
        e.done_cyc = cyc + exp_lat(a, b);
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_auto(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) drive_op(a, b, '1, a, 1'b1);
        else         drive_op(a, b, a / b, a % b, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        int d_cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
        vecs[1] = '{a: 32'h0000_1234,  b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h0000_1234,  dz: 1'b1};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dz: 1'b0};
        vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b0};
        vecs[4] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          dz: 1'b0};
        vecs[5] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          dz: 1'b0};
        vecs[6] = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b1};
        vecs[7] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'd715827882,  r: 32'd2,          dz: 1'b0};
        vecs[8] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'hFFFF_FFFE,  dz: 1'b0};
        vecs[9] = '{a: 32'hDEAD_BEEF,  b: 32'h0000_0010,  q: 32'h0DEA_DBEE,  r: 32'h0000_000F,  dz: 1'b0};

        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
            wait_idle(60);
        end

        // Abort/restart: second start ten cycles in replaces the first op.
        drive_auto(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        drive_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        wait_idle(60);

        // Back-to-back: new start lands in the cycle done asserts.
        drive_auto(32'd200, 32'd7);
        d_cyc = sb[$].done_cyc;
        while (cyc < d_cyc) @(negedge clk);
        drive_auto(32'd9, 32'd4);
        d_cyc = sb[$].done_cyc;
        while (cyc < d_cyc) @(negedge clk);
        drive_auto(32'h0000_0777, 32'd0);
        wait_idle(60);

        // Reset mid-operation drops the op silently.
        drive_auto(32'd77, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) begin
                rb = '0;
            end else begin
                rb = $urandom() >> $urandom_range(0, 31);
                if (rb == '0) rb = 32'd1;
            end
            drive_auto(ra, rb);
            wait_idle(60);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
